vsync_capture_ctrl: RTL and testbench

//  Frame-capture sequencer on the clk side of vsync: gates vsync's AXI-stream pixel output into whole, geometry-checked frames for the downstream DMA.

---
 rtl/vsync_capture_ctrl_pkg.sv | 16 +
 rtl/vsync_capture_ctrl_axis_reg_slice.sv | 38 +++
 rtl/vsync_capture_ctrl.sv | 164 ++++++++++++++++
 tb/tb_vsync_capture_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vsync_capture_ctrl_pkg.sv
// Shared types and default geometry for the vsync frame-capture sequencer.
package vsync_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_CAPTURE,
    ST_DRAIN
  } state_e;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_WIDTH_PIX    = 640;
  localparam int DEF_HEIGHT_LINES = 480;
  localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/vsync_capture_ctrl_axis_reg_slice.sv
// Single-entry AXI-stream register stage (data/last/user); full throughput when downstream is ready.
module axis_reg_slice #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_user,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_user
);

  // Caller only asserts load while in_ready, so a presented beat is never overwritten.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
      out_user  <= in_user;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vsync_capture_ctrl.sv
// Frame-capture sequencer: gates the vsync pixel stream into whole, geometry-checked frames.
module vsync_capture_ctrl
  import vsync_capture_ctrl_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int WIDTH_PIX    = DEF_WIDTH_PIX,
  parameter int HEIGHT_LINES = DEF_HEIGHT_LINES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              continuous,
  input  logic              abort,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  input  logic              overflow,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_count,
  output logic              err_geom,
  output logic              err_ovf
);

  state_e           state;
  logic [CNT_W-1:0] pix, line;
  logic             slot_free, acc, load;
  logic             fwd, fwd_last, geom_hit, ovf_hit;
  logic             pix_end, line_end;

  assign pix_end  = (pix == CNT_W'(WIDTH_PIX - 1));
  assign line_end = (line == CNT_W'(HEIGHT_LINES - 1));

  // Idle discards at full rate; WAIT_SOF also waits on the slot so a held beat is never clobbered.
  always_comb begin
    s_axis_tready = 1'b0;
    case (state)
      ST_IDLE:     s_axis_tready = 1'b1;
      ST_WAIT_SOF: s_axis_tready = slot_free;
      ST_CAPTURE:  s_axis_tready = slot_free;
      default:     s_axis_tready = 1'b0;
    endcase
  end

  assign acc  = s_axis_tvalid && s_axis_tready;
  assign load = fwd && !abort;
  assign busy = (state != ST_IDLE) || m_axis_tvalid;

  always_comb begin
    fwd      = 1'b0;
    fwd_last = 1'b0;
    geom_hit = 1'b0;
    ovf_hit  = 1'b0;
    case (state)
      ST_WAIT_SOF: begin
        if (overflow)                  ovf_hit = 1'b1;
        else if (acc && s_axis_tuser)  fwd = 1'b1;
      end
      ST_CAPTURE: begin
        if (overflow) ovf_hit = 1'b1;
        else if (acc) begin
          if (s_axis_tuser) begin
            // Mid-frame SOF restarts the frame in place.
            geom_hit = 1'b1;
            fwd      = 1'b1;
          end else if (s_axis_tlast) begin
            if (pix_end) begin
              fwd      = 1'b1;
              fwd_last = line_end;
            end else begin
              geom_hit = 1'b1;
            end
          end else if (pix_end) begin
            geom_hit = 1'b1;
          end else begin
            fwd = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  axis_reg_slice #(.DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .in_data   (s_axis_tdata),
    .in_last   (fwd_last),
    .in_user   (s_axis_tuser),
    .in_ready  (slot_free),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (m_axis_tdata),
    .out_last  (m_axis_tlast),
    .out_user  (m_axis_tuser)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pix         <= '0;
      line        <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      err_geom    <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_geom   <= (err_geom && !err_clr) || (geom_hit && !abort);
      err_ovf    <= (err_ovf && !err_clr) || (ovf_hit && !abort);
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (arm) state <= ST_WAIT_SOF;
          ST_WAIT_SOF: begin
            if (load) begin
              pix   <= CNT_W'(1);
              line  <= '0;
              state <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (ovf_hit) begin
              state <= ST_WAIT_SOF;
            end else if (acc) begin
              if (s_axis_tuser) begin
                pix  <= CNT_W'(1);
                line <= '0;
              end else if (geom_hit) begin
                state <= ST_WAIT_SOF;
              end else if (s_axis_tlast) begin
                if (line_end) state <= ST_DRAIN;
                line <= line + 1'b1;
                pix  <= '0;
              end else begin
                pix <= pix + 1'b1;
              end
            end
          end
          ST_DRAIN: begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 1'b1;
              state       <= continuous ? ST_WAIT_SOF : ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vsync_capture_ctrl.sv
// Directed bench for vsync_capture_ctrl on a 4x3 frame geometry.
module tb_vsync_capture_ctrl;
  localparam int DW = 8, WP = 4, HL = 3, CW = 16;

  logic clk = 1'b0, reset_n = 1'b1;
  always #5 clk = ~clk;

  logic          arm = 0, continuous = 0, abort = 0, err_clr = 0, overflow = 0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 0, s_tlast = 0, s_tuser = 0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic          m_tready = 1'b1, rnd_rdy = 1'b0, rdy_lvl = 1'b1;
  logic          busy, frame_done, err_geom, err_ovf;
  logic [CW-1:0] frame_count;

  vsync_capture_ctrl #(.DATA_W(DW), .WIDTH_PIX(WP), .HEIGHT_LINES(HL), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .continuous(continuous), .abort(abort),
    .err_clr(err_clr), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .overflow(overflow), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
    .err_geom(err_geom), .err_ovf(err_ovf)
  );

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) begin
    #1;
    m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_lvl;
  end

  // Output monitor: records handshakes, frame_done pulses and valid/data hold violations.
  logic [9:0] got_q[$], exp_q[$];
  int         fd_cnt = 0, hold_viol = 0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;
  always @(negedge clk) begin
    if (m_axis_tvalid && m_tready) got_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    if (frame_done) fd_cnt++;
    if (reset_n && prev_stall && (!m_axis_tvalid || {m_axis_tuser, m_axis_tlast, m_axis_tdata} != prev_beat))
      hold_viol++;
    prev_stall = reset_n && m_axis_tvalid && !m_tready;
    prev_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic u, input bit fwd, input bit flast);
    bit ok = 0;
    s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #2;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    if (!ok) chk("send_accept", 32'(ok), 1);
    if (fwd) exp_q.push_back({u, flast, d});
  endtask

  // Beat k of frame f carries f*16+k; fwd_from selects which beats should reach m_axis.
  task automatic send_beats(input int f, input int from, input int to, input bit fwd);
    for (int k = from; k <= to; k++)
      send(8'(f * 16 + k), (k % WP) == WP - 1, k == 0, fwd, k == WP * HL - 1);
  endtask

  task automatic wait_fd(input int target);
    for (int i = 0; i < 3000 && fd_cnt < target; i++) tick();
    if (fd_cnt < target) chk("frame_done_wait", fd_cnt, target);
  endtask

  task automatic cmp_q(input string tag);
    int n;
    chk($sformatf("%s_len", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) chk($sformatf("%s_beat%0d", tag, k), got_q[k], exp_q[k]);
    got_q.delete();
    exp_q.delete();
  endtask

  int fd0;

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("rst_s_tready", s_axis_tready, 1);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {frame_done, err_geom, err_ovf}, 0);
    chk("rst_fcount", frame_count, 0);
    #19 reset_n = 1'b1;
    tick();

    // 1: single-shot frame after junk
    fd0 = fd_cnt;
    arm = 1; tick(); arm = 0;
    send(8'hAA, 0, 0, 0, 0);
    send(8'hBB, 1, 0, 0, 0);
    send_beats(1, 0, 11, 1);
    wait_fd(fd0 + 1);
    repeat (3) tick();
    cmp_q("t1");
    chk("t1_fd", fd_cnt - fd0, 1);
    chk("t1_fcount", frame_count, 1);
    chk("t1_busy", busy, 0);

    // 2: continuous, three frames, random backpressure
    fd0 = fd_cnt;
    continuous = 1; rnd_rdy = 1;
    arm = 1; tick(); arm = 0;
    send_beats(2, 0, 11, 1);
    send_beats(3, 0, 11, 1);
    send_beats(4, 0, 11, 1);
    wait_fd(fd0 + 3);
    rnd_rdy = 0; continuous = 0;
    repeat (2) tick();
    abort = 1; tick(); abort = 0;
    tick();
    cmp_q("t2");
    chk("t2_fd", fd_cnt - fd0, 3);
    chk("t2_fcount", frame_count, 4);
    chk("t2_hold", hold_viol, 0);
    chk("t2_busy", busy, 0);

    // 3: short line -> geometry error, resync on next frame
    fd0 = fd_cnt;
    arm = 1; tick(); arm = 0;
    send_beats(5, 0, 5, 1);
    send(8'h56, 1, 0, 0, 0);
    chk("t3_err_geom", err_geom, 1);
    chk("t3_busy_wait", busy, 1);
    send_beats(6, 0, 11, 1);
    wait_fd(fd0 + 1);
    repeat (2) tick();
    cmp_q("t3");
    chk("t3_fcount", frame_count, 5);
    chk("t3_err_geom_hold", err_geom, 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("t3_err_clr", err_geom, 0);

    // 4: overflow mid-frame
    fd0 = fd_cnt;
    arm = 1; tick(); arm = 0;
    send_beats(7, 0, 4, 1);
    overflow = 1; tick(); overflow = 0;
    chk("t4_err_ovf", err_ovf, 1);
    send_beats(7, 5, 11, 0);
    chk("t4_fcount_bad", frame_count, 5);
    send_beats(8, 0, 11, 1);
    wait_fd(fd0 + 1);
    repeat (2) tick();
    cmp_q("t4");
    chk("t4_fd", fd_cnt - fd0, 1);
    chk("t4_fcount", frame_count, 6);
    chk("t4_err_geom", err_geom, 0);
    err_clr = 1; tick(); err_clr = 0;
    chk("t4_err_clr", err_ovf, 0);

    // 5: abort with a stalled beat
    fd0 = fd_cnt;
    rdy_lvl = 0; tick();
    arm = 1; tick(); arm = 0;
    send(8'h90, 0, 1, 1, 0);
    tick();
    chk("t5_pend_valid", m_axis_tvalid, 1);
    abort = 1; tick(); abort = 0;
    chk("t5_hold_valid", m_axis_tvalid, 1);
    chk("t5_hold_data", m_axis_tdata, 8'h90);
    chk("t5_busy_pend", busy, 1);
    rdy_lvl = 1;
    repeat (4) tick();
    chk("t5_busy", busy, 0);
    chk("t5_fd", fd_cnt - fd0, 0);
    chk("t5_fcount", frame_count, 6);
    cmp_q("t5");

    // 6: asynchronous reset mid-frame, then resume
    fd0 = fd_cnt;
    arm = 1; tick(); arm = 0;
    send_beats(10, 0, 5, 1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("t6_m_tvalid", m_axis_tvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_fcount", frame_count, 0);
    chk("t6_s_tready", s_axis_tready, 1);
    chk("t6_outs", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, 0);
    #3 reset_n = 1'b1;
    tick();
    cmp_q("t6a");
    arm = 1; tick(); arm = 0;
    send_beats(11, 0, 11, 1);
    wait_fd(fd0 + 1);
    repeat (2) tick();
    cmp_q("t6b");
    chk("t6_fcount_after", frame_count, 1);
    chk("t6_hold", hold_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
